game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter BOARD_N, default 7, meaning board edge length in cells.
REQ-002 SHALL have parameter MAX_MOVES, default 49, meaning the move count at which the game is declared drawn.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit, reset; it is asynchronous and active-low.
REQ-005 SHALL have port new_game, input, 1 bit, one-cycle request to abandon the current game and start a new one.
REQ-006 SHALL have port mv_valid, input, 1 bit, a requested move is present on mv_x/mv_y.
REQ-007 SHALL have port mv_x, input, 3 bits, requested row.
REQ-008 SHALL have port mv_y, input, 3 bits, requested column.
REQ-009 SHALL have port mv_ready, output, 1 bit, controller can accept a move this cycle.
REQ-010 SHALL have port mv_reject, output, 1 bit, one-cycle pulse: offered move refused.
REQ-011 SHALL have port brd_go, output, 1 bit, write strobe to the board store.
REQ-012 SHALL have port brd_x, output, 3 bits, board write row.
REQ-013 SHALL have port brd_y, output, 3 bits, board write column.
REQ-014 SHALL have port brd_color, output, 1 bit, stone color written (0 black, 1 white).
REQ-015 SHALL have port brd_clr_n, output, 1 bit, active-low board clear; the board samples it synchronously.
REQ-016 SHALL have port brd_state, input, 2 bits, board result (0 none, 1 black win, 2 white win, 3 illegal).
REQ-017 SHALL have port turn, output, 1 bit, color to move.
REQ-018 SHALL have port game_over, output, 1 bit, the game has ended.
REQ-019 SHALL have port winner, output, 2 bits, result (0 none/draw, 1 black, 2 white).
REQ-020 SHALL have port move_cnt, output, 6 bits, number of stones placed.

Function
REQ-021 SHALL implement the FSM states CLEAR, WAIT_MOVE, PLACE, CHECK and OVER.
REQ-022 CLEAR SHALL drive brd_clr_n=0 for exactly one cycle, zero the occupancy map, move_cnt, turn and winner, then go to WAIT_MOVE.
REQ-023 WAIT_MOVE SHALL assert mv_ready; a handshake occurs when mv_valid && mv_ready.
REQ-024 On a handshake with mv_x or mv_y >= BOARD_N, or with the target cell already occupied, the controller SHALL pulse mv_reject the next cycle and stay in WAIT_MOVE.
REQ-025 On a legal handshake the controller SHALL latch x/y and go to PLACE.
REQ-026 PLACE SHALL assert brd_go for exactly one cycle with the latched x/y and brd_color=turn, set the occupancy bit and increment move_cnt.
REQ-027 CHECK SHALL sample brd_state one cycle after brd_go, and its outcome SHALL be exactly one of the following:
- brd_state 1 or 2 -> winner=brd_state, OVER.
- else move_cnt==MAX_MOVES -> winner=0, OVER.
- else toggle turn, WAIT_MOVE.
REQ-028 brd_state==3 SHALL be treated as 0.
REQ-029 mv_ready SHALL re-assert exactly 3 cycles after an accepted legal move (PLACE, CHECK, WAIT_MOVE).
REQ-030 OVER SHALL hold game_over=1, mv_ready=0 and winner/move_cnt stable, and SHALL ignore mv_valid.
REQ-031 new_game in any state SHALL force CLEAR next cycle, overriding a same-cycle handshake; if new_game arrives during PLACE, the brd_go write of that cycle still completes.
REQ-032 mv_reject, brd_go and brd_clr_n low SHALL be mutually exclusive.

Reset
REQ-033 While resetn=0 the controller SHALL be asynchronously forced to state CLEAR with mv_ready=0, mv_reject=0, brd_go=0, brd_clr_n=0, turn=0, game_over=0, winner=0, move_cnt=0 and brd_x=brd_y=0.
REQ-034 Reset release SHALL be followed by the normal one-cycle CLEAR step.
REQ-035 Reset asserted mid-game SHALL discard any latched move.

Structure
REQ-036 Package gomoku_pkg SHALL hold BOARD_N, the color encodings, the result codes (NONE/BLACK/WHITE) and the FSM state enum.
REQ-037 Sub-module occ_map SHALL hold a BOARD_N*BOARD_N-bit register with clear, set(x,y) and combinational read(x,y) ports.

Verification
REQ-038 Reset then legal moves (3,3), (0,0) -> brd_go with color 0 then 1; turn ends 0; move_cnt=2; mv_ready gaps of 3 cycles.
REQ-039 Move (3,3) then repeat (3,3) -> second move gives mv_reject pulse, no brd_go, move_cnt=1, turn=1.
REQ-040 Move (7,2) -> mv_reject pulse, no state change.
REQ-041 Black plays row 3, cols 1..5 interleaved with white moves; model brd_state=1 after the fifth black stone -> game_over=1, winner=1, subsequent mv_valid ignored.
REQ-042 49 legal moves with brd_state held 0 -> game_over=1, winner=0, move_cnt=49.
REQ-043 new_game asserted in the PLACE cycle -> brd_go completes, then brd_clr_n low one cycle, move_cnt=0, turn=0; async reset mid-CHECK gives the same final state.

Source files
------------

// File: rtl/gomoku_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gomoku_pkg
// Brief    : Shared constants, result codes and FSM state type for game_ctrl.
// Revision : 1.0
// ============================================================================
package gomoku_pkg;

    localparam int BOARD_N = 7;

    localparam logic COLOR_BLACK = 1'b0;
    localparam logic COLOR_WHITE = 1'b1;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_BLACK   = 2'd1;
    localparam logic [1:0] RES_WHITE   = 2'd2;
    localparam logic [1:0] RES_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        S_CLEAR     = 3'd0,
        S_WAIT_MOVE = 3'd1,
        S_PLACE     = 3'd2,
        S_CHECK     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/occ_map.sv
`default_nettype none
// ============================================================================
// Module   : occ_map
// Brief    : One occupancy bit per board cell; sync clear, sync set, comb read.
// Revision : 1.0
// ============================================================================
module occ_map #(
    parameter int BOARD_N = gomoku_pkg::BOARD_N
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       set,
    input  logic [2:0] set_x,
    input  logic [2:0] set_y,
    input  logic [2:0] rd_x,
    input  logic [2:0] rd_y,
    output logic       rd
);

    localparam int CELLS = BOARD_N * BOARD_N;

    logic [CELLS-1:0] cells;
    logic [CELLS-1:0] set_mask;
    logic [CELLS-1:0] hit;

    // Per-cell decode keeps out-of-range coordinates from aliasing onto real cells.
    for (genvar gx = 0; gx < BOARD_N; gx++) begin : g_row
        for (genvar gy = 0; gy < BOARD_N; gy++) begin : g_col
            assign set_mask[gx*BOARD_N+gy] = (set_x == 3'(gx)) && (set_y == 3'(gy));
            assign hit[gx*BOARD_N+gy]      = cells[gx*BOARD_N+gy] &&
                                             (rd_x == 3'(gx)) && (rd_y == 3'(gy));
        end
    end

    assign rd = |hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cells <= '0;
        end else if (clr) begin
            cells <= '0;
        end else if (set) begin
            cells <= cells | set_mask;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Brief    : Gomoku move sequencer: validates moves, drives board writes, ends game.
// Revision : 1.0
// ============================================================================
module game_ctrl #(
    parameter int BOARD_N   = gomoku_pkg::BOARD_N,
    parameter int MAX_MOVES = 49
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       new_game,
    input  logic       mv_valid,
    input  logic [2:0] mv_x,
    input  logic [2:0] mv_y,
    output logic       mv_ready,
    output logic       mv_reject,
    output logic       brd_go,
    output logic [2:0] brd_x,
    output logic [2:0] brd_y,
    output logic       brd_color,
    output logic       brd_clr_n,
    input  logic [1:0] brd_state,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [5:0] move_cnt
);

    import gomoku_pkg::*;

    state_t     state;
    logic       in_range;
    logic       occupied;
    logic [1:0] result;

    assign in_range = ({1'b0, mv_x} < 4'(BOARD_N)) && ({1'b0, mv_y} < 4'(BOARD_N));
    assign result   = (brd_state == RES_ILLEGAL) ? RES_NONE : brd_state;

    // brd_x/brd_y double as the latched move, so PLACE writes the map from them.
    occ_map #(.BOARD_N(BOARD_N)) u_occ (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state == S_CLEAR),
        .set    (state == S_PLACE),
        .set_x  (brd_x),
        .set_y  (brd_y),
        .rd_x   (mv_x),
        .rd_y   (mv_y),
        .rd     (occupied)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_CLEAR;
            mv_ready  <= 1'b0;
            mv_reject <= 1'b0;
            brd_go    <= 1'b0;
            brd_x     <= 3'd0;
            brd_y     <= 3'd0;
            brd_color <= COLOR_BLACK;
            brd_clr_n <= 1'b0;
            turn      <= COLOR_BLACK;
            game_over <= 1'b0;
            winner    <= RES_NONE;
            move_cnt  <= 6'd0;
        end else begin
            mv_reject <= 1'b0;
            brd_go    <= 1'b0;
            brd_clr_n <= 1'b1;
            if (new_game) begin
                state     <= S_CLEAR;
                mv_ready  <= 1'b0;
                brd_clr_n <= 1'b0;
                turn      <= COLOR_BLACK;
                game_over <= 1'b0;
                winner    <= RES_NONE;
                move_cnt  <= 6'd0;
            end else begin
                case (state)
                    S_CLEAR: begin
                        state     <= S_WAIT_MOVE;
                        mv_ready  <= 1'b1;
                        turn      <= COLOR_BLACK;
                        game_over <= 1'b0;
                        winner    <= RES_NONE;
                        move_cnt  <= 6'd0;
                    end
                    S_WAIT_MOVE: begin
                        if (mv_valid && mv_ready) begin
                            if (!in_range || occupied) begin
                                mv_reject <= 1'b1;
                            end else begin
                                state     <= S_PLACE;
                                mv_ready  <= 1'b0;
                                brd_go    <= 1'b1;
                                brd_x     <= mv_x;
                                brd_y     <= mv_y;
                                brd_color <= turn;
                            end
                        end
                    end
                    S_PLACE: begin
                        state    <= S_CHECK;
                        move_cnt <= move_cnt + 6'd1;
                    end
                    S_CHECK: begin
                        if (result == RES_BLACK || result == RES_WHITE) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                            winner    <= result;
                        end else if (move_cnt == 6'(MAX_MOVES)) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                            winner    <= RES_NONE;
                        end else begin
                            state    <= S_WAIT_MOVE;
                            mv_ready <= 1'b1;
                            turn     <= (turn == COLOR_BLACK) ? COLOR_WHITE : COLOR_BLACK;
                        end
                    end
                    S_OVER: begin
                        state <= S_OVER;
                    end
                    default: begin
                        state <= S_CLEAR;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Brief    : Directed bench for game_ctrl with a move-level reference model.
// Revision : 1.0
// ============================================================================
module tb_game_ctrl;

    localparam int N    = 7;
    localparam int MAXM = 49;

    logic       clk = 1'b0;
    logic       resetn;
    logic       new_game;
    logic       mv_valid;
    logic [2:0] mv_x;
    logic [2:0] mv_y;
    logic       mv_ready;
    logic       mv_reject;
    logic       brd_go;
    logic [2:0] brd_x;
    logic [2:0] brd_y;
    logic       brd_color;
    logic       brd_clr_n;
    logic [1:0] brd_state;
    logic       turn;
    logic       game_over;
    logic [1:0] winner;
    logic [5:0] move_cnt;

    game_ctrl #(.BOARD_N(N), .MAX_MOVES(MAXM)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .new_game  (new_game),
        .mv_valid  (mv_valid),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .mv_ready  (mv_ready),
        .mv_reject (mv_reject),
        .brd_go    (brd_go),
        .brd_x     (brd_x),
        .brd_y     (brd_y),
        .brd_color (brd_color),
        .brd_clr_n (brd_clr_n),
        .brd_state (brd_state),
        .turn      (turn),
        .game_over (game_over),
        .winner    (winner),
        .move_cnt  (move_cnt)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle plus the game as the rules see it.
    logic       m_ready, m_reject, m_go, m_clr_n, m_turn, m_over, m_color, m_chk_xy;
    logic [1:0] m_winner;
    int         m_cnt;
    logic [2:0] m_x, m_y;
    bit         occ [8][8];

    int vectors     = 0;
    int miscompares = 0;
    int cyc = 0, last_rise = 0, gap = 0;
    logic prev_ready = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        chk("mv_ready",  8'(mv_ready),  8'(m_ready));
        chk("mv_reject", 8'(mv_reject), 8'(m_reject));
        chk("brd_go",    8'(brd_go),    8'(m_go));
        chk("brd_clr_n", 8'(brd_clr_n), 8'(m_clr_n));
        chk("turn",      8'(turn),      8'(m_turn));
        chk("game_over", 8'(game_over), 8'(m_over));
        chk("winner",    8'(winner),    8'(m_winner));
        chk("move_cnt",  8'(move_cnt),  8'(m_cnt));
        if (m_chk_xy) begin
            chk("brd_x", 8'(brd_x), 8'(m_x));
            chk("brd_y", 8'(brd_y), 8'(m_y));
        end
        if (m_go) chk("brd_color", 8'(brd_color), 8'(m_color));
        if (mv_ready === 1'b1 && prev_ready !== 1'b1) begin
            gap       = cyc - last_rise;
            last_rise = cyc;
        end
        prev_ready = mv_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_occ();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                occ[i][j] = 1'b0;
    endtask

    task automatic model_reset();
        m_ready = 0; m_reject = 0; m_go = 0; m_clr_n = 0; m_turn = 0;
        m_over = 0; m_winner = 2'd0; m_cnt = 0; m_color = 0;
        m_x = 3'd0; m_y = 3'd0; m_chk_xy = 1;
        clear_occ();
    endtask

    task automatic model_clear();
        m_ready = 0; m_reject = 0; m_go = 0; m_clr_n = 0; m_turn = 0;
        m_over = 0; m_winner = 2'd0; m_cnt = 0; m_chk_xy = 0;
        clear_occ();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        tick();
        tick();
        resetn   = 1'b1;
        m_chk_xy = 0;
        tick();
        m_clr_n = 1; m_ready = 1;
    endtask

    task automatic start_new();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
        tick();
        m_clr_n = 1; m_ready = 1;
    endtask

    // Offer a move the moment the controller is ready; bs is the board verdict.
    task automatic play(input int x, input int y, input logic [1:0] bs);
        bit legal;
        legal    = (x < N) && (y < N) && !occ[x][y];
        mv_valid = 1'b1; mv_x = 3'(x); mv_y = 3'(y);
        tick();
        mv_valid = 1'b0;
        if (!legal) begin
            m_reject = 1;
            tick();
            m_reject = 0;
        end else begin
            m_ready = 0; m_go = 1; m_color = m_turn; m_chk_xy = 1;
            m_x = 3'(x); m_y = 3'(y);
            brd_state = bs;
            tick();
            m_go = 0; m_chk_xy = 0; m_cnt++; occ[x][y] = 1'b1;
            tick();
            brd_state = 2'd0;
            if (bs == 2'd1 || bs == 2'd2) begin
                m_over = 1; m_winner = bs;
            end else if (m_cnt == MAXM) begin
                m_over = 1; m_winner = 2'd0;
            end else begin
                m_turn = ~m_turn; m_ready = 1;
            end
        end
    endtask

    initial begin
        new_game = 0; mv_valid = 0; mv_x = 0; mv_y = 0; brd_state = 0;
        do_reset();

        // Two legal moves, colors alternate, ready returns after 3 cycles
        play(3, 3, 2'd0);
        play(0, 0, 2'd0);
        tick();
        chk("t038_cnt",  8'(move_cnt), 8'd2);
        chk("t038_turn", 8'(turn),     8'd0);
        chk("t038_gap",  8'(gap),      8'd3);

        // Occupied cell and off-board row are refused
        start_new();
        play(3, 3, 2'd0);
        play(3, 3, 2'd0);
        chk("t039_cnt",  8'(move_cnt), 8'd1);
        chk("t039_turn", 8'(turn),     8'd1);
        play(7, 2, 2'd0);
        play(2, 7, 2'd0);
        chk("t040_cnt",  8'(move_cnt), 8'd1);
        chk("t040_turn", 8'(turn),     8'd1);

        // Black five in a row wins; later moves are ignored
        start_new();
        for (int k = 0; k < 5; k++) begin
            play(3, k + 1, (k == 4) ? 2'd1 : 2'd0);
            if (k < 4) play(0, k + 1, 2'd0);
        end
        mv_valid = 1'b1; mv_x = 3'd1; mv_y = 3'd1;
        repeat (3) tick();
        mv_valid = 1'b0;
        chk("t041_over",   8'(game_over), 8'd1);
        chk("t041_winner", 8'(winner),    8'd1);
        chk("t041_cnt",    8'(move_cnt),  8'd9);

        // Full board is a draw; illegal board verdicts count as no result
        start_new();
        for (int i = 0; i < N * N; i++)
            play(i / N, i % N, (i % 5 == 2) ? 2'd3 : 2'd0);
        tick();
        chk("t042_over",   8'(game_over), 8'd1);
        chk("t042_winner", 8'(winner),    8'd0);
        chk("t042_cnt",    8'(move_cnt),  8'd49);

        // new_game during the board write
        start_new();
        mv_valid = 1'b1; mv_x = 3'd2; mv_y = 3'd2;
        tick();
        mv_valid = 1'b0;
        m_ready = 0; m_go = 1; m_color = m_turn; m_chk_xy = 1; m_x = 3'd2; m_y = 3'd2;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
        tick();
        m_clr_n = 1; m_ready = 1;
        chk("t043_ng_cnt",  8'(move_cnt), 8'd0);
        chk("t043_ng_turn", 8'(turn),     8'd0);

        // Asynchronous reset while the move is being checked
        play(0, 0, 2'd0);
        play(2, 2, 2'd0);
        mv_valid = 1'b1; mv_x = 3'd4; mv_y = 3'd4;
        tick();
        mv_valid = 1'b0;
        m_ready = 0; m_go = 1; m_color = m_turn; m_chk_xy = 1; m_x = 3'd4; m_y = 3'd4;
        tick();
        m_go = 0; m_chk_xy = 0; m_cnt++; occ[4][4] = 1'b1;
        do_reset();
        chk("t043_rst_cnt",  8'(move_cnt), 8'd0);
        chk("t043_rst_turn", 8'(turn),     8'd0);
        play(4, 4, 2'd0);
        chk("t043_replay_cnt", 8'(move_cnt), 8'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
